// File: rtl/ss_restore_reader_pkg.sv
// Shared save-state constants and types.
// Contents: DDR base address, chunk header magic, terminator SSIDX, checksum seed,
// the chunk header layout and the restore FSM state type.
package system_consts;

  localparam logic [31:0] SS_DDR_BASE       = 32'h3E00_0000;
  localparam logic [15:0] SS_CHUNK_MAGIC    = 16'h5353;
  localparam logic [7:0]  SS_IDX_TERMINATOR = 8'hFF;
  localparam logic [63:0] SS_CSUM_SEED      = 64'hA5A5_A5A5_A5A5_A5A5;

  typedef struct packed {
    logic [15:0] magic;
    logic [7:0]  idx;
    logic [7:0]  rsvd;
    logic [31:0] length;
  } ss_chunk_hdr_t;

  typedef enum logic [2:0] {
    StIdle,
    StHdrRd,
    StDatRd,
    StDatOut,
    StCsumRd,
    StDone,
    StError
  } ss_restore_state_t;

endpackage

// File: rtl/ss_ddr_word_fetch.sv
// Single-word DDR read engine for the save-state restore reader.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   fetch                 level request from the parent FSM to read the word at ddr_addr
//   load_base             rewind ddr_addr to BASE_ADDR
//   ddr_addr/ddr_req      DDR read port (request held until ddr_rvalid)
//   ddr_rdata/ddr_rvalid  DDR read data / completion pulse
//   word_valid/word       accepted read data, same cycle as ddr_rvalid
module ss_ddr_word_fetch
  import system_consts::*;
#(
  parameter logic [31:0] BASE_ADDR = SS_DDR_BASE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch,
  input  logic        load_base,
  output logic [31:0] ddr_addr,
  output logic        ddr_req,
  input  logic [63:0] ddr_rdata,
  input  logic        ddr_rvalid,
  output logic        word_valid,
  output logic [63:0] word
);

  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;

  // rvalid without an outstanding request is ignored
  assign word_valid = req_q && ddr_rvalid;
  assign word       = ddr_rdata;
  assign ddr_addr   = addr_q;
  assign ddr_req    = req_q;

  always_comb begin
    addr_d = addr_q;
    req_d  = req_q;
    if (load_base) begin
      addr_d = BASE_ADDR;
    end else if (word_valid) begin
      addr_d = addr_q + 32'd8;  // wraps modulo 2^32
    end
    // Completion wins over fetch so req always drops for a cycle after rvalid
    if (word_valid) begin
      req_d = 1'b0;
    end else if (fetch) begin
      req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= BASE_ADDR;
      req_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      req_q  <= req_d;
    end
  end

endmodule

// File: rtl/ss_restore_reader.sv
// Save-state restore engine: walks the chunk stream in DDR, validates each header and
// replays payload words to the unit selected by the chunk's SSIDX.
// Optional feature: define SS_RESTORE_CHECKSUM_EN to require and verify a checksum word
// after every non-empty chunk.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start/busy/done/error    control and status (error sticky until next start)
//   ddr_*                    DDR read arbiter port
//   ss_idx/ss_chunk_start    current chunk SSIDX and per-chunk start pulse
//   ss_data/ss_valid/ss_ready payload word handshake
module ss_restore_reader
  import system_consts::*;
#(
  parameter logic [31:0] BASE_ADDR = SS_DDR_BASE,
  parameter int unsigned NUM_IDX   = 18,
  parameter logic [31:0] MAX_WORDS = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] ddr_addr,
  output logic        ddr_req,
  input  logic [63:0] ddr_rdata,
  input  logic        ddr_rvalid,
  output logic [7:0]  ss_idx,
  output logic        ss_chunk_start,
  output logic [63:0] ss_data,
  output logic        ss_valid,
  input  logic        ss_ready
);

  ss_restore_state_t state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  idx_q, idx_d;
  logic        chunk_start_q, chunk_start_d;
  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        fetch, load_base, word_valid;
  logic [63:0] word;
  ss_chunk_hdr_t hdr;
  logic        hdr_bad;
  logic        unused_rsvd;
`ifdef SS_RESTORE_CHECKSUM_EN
  logic [63:0] acc_q, acc_d;
`endif

  ss_ddr_word_fetch #(
    .BASE_ADDR (BASE_ADDR)
  ) u_fetch (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch      (fetch),
    .load_base  (load_base),
    .ddr_addr   (ddr_addr),
    .ddr_req    (ddr_req),
    .ddr_rdata  (ddr_rdata),
    .ddr_rvalid (ddr_rvalid),
    .word_valid (word_valid),
    .word       (word)
  );

  assign hdr         = ss_chunk_hdr_t'(word);
  assign unused_rsvd = ^hdr.rsvd;
  // Validity is checked before the terminator test, so a terminator with an oversize
  // length is still an error.
  assign hdr_bad = (hdr.magic != SS_CHUNK_MAGIC) ||
                   ((hdr.idx != SS_IDX_TERMINATOR) && (32'(hdr.idx) >= NUM_IDX)) ||
                   (hdr.length > MAX_WORDS);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    idx_d         = idx_q;
    chunk_start_d = 1'b0;
    data_d        = data_q;
    valid_d       = valid_q;
    error_d       = error_q;
    fetch         = 1'b0;
    load_base     = 1'b0;
`ifdef SS_RESTORE_CHECKSUM_EN
    acc_d         = acc_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          load_base = 1'b1;
          error_d   = 1'b0;
          state_d   = StHdrRd;
        end
      end
      StHdrRd: begin
        fetch = 1'b1;
        if (word_valid) begin
          if (hdr_bad) begin
            state_d = StError;
          end else if (hdr.idx == SS_IDX_TERMINATOR) begin
            state_d = StDone;
          end else begin
            idx_d         = hdr.idx;
            count_d       = hdr.length;
            chunk_start_d = 1'b1;
`ifdef SS_RESTORE_CHECKSUM_EN
            acc_d         = '0;
`endif
            state_d = (hdr.length == 32'd0) ? StHdrRd : StDatRd;
          end
        end
      end
      StDatRd: begin
        fetch = 1'b1;
        if (word_valid) begin
          data_d  = word;
          valid_d = 1'b1;
          state_d = StDatOut;
        end
      end
      StDatOut: begin
        if (valid_q && ss_ready) begin
          valid_d = 1'b0;
          count_d = count_q - 32'd1;
`ifdef SS_RESTORE_CHECKSUM_EN
          acc_d   = acc_q ^ data_q;
          state_d = (count_q == 32'd1) ? StCsumRd : StDatRd;
`else
          state_d = (count_q == 32'd1) ? StHdrRd : StDatRd;
`endif
        end
      end
`ifdef SS_RESTORE_CHECKSUM_EN
      StCsumRd: begin
        fetch = 1'b1;
        if (word_valid) begin
          state_d = (word == (acc_q ^ SS_CSUM_SEED)) ? StHdrRd : StError;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      StError: begin
        error_d = 1'b1;
        valid_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      count_q       <= '0;
      idx_q         <= '0;
      chunk_start_q <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      error_q       <= 1'b0;
`ifdef SS_RESTORE_CHECKSUM_EN
      acc_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      chunk_start_q <= chunk_start_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      error_q       <= error_d;
`ifdef SS_RESTORE_CHECKSUM_EN
      acc_q         <= acc_d;
`endif
    end
  end

  assign busy           = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);
  assign done           = (state_q == StDone);
  assign error          = error_q;
  assign ss_idx         = idx_q;
  assign ss_chunk_start = chunk_start_q;
  assign ss_data        = data_q;
  assign ss_valid       = valid_q;

endmodule

// File: tb/tb_ss_restore_reader.sv
// Self-checking bench for ss_restore_reader: header table, hand-written corner cases
// and randomized chunk streams checked against a stream-walking reference model.
module tb_ss_restore_reader;

  localparam logic [31:0] BASE = 32'h3E00_0000;
  localparam int unsigned NIDX = 18;
  localparam logic [31:0] MAXW = 32'h0010_0000;
  localparam logic [63:0] SEED = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] TERM = {16'h5353, 8'hFF, 8'h00, 32'd0};

  logic        clk = 1'b0;
  logic        reset_n, start, busy, done, error;
  logic [31:0] ddr_addr;
  logic        ddr_req, ddr_rvalid;
  logic [63:0] ddr_rdata, ss_data;
  logic [7:0]  ss_idx;
  logic        ss_chunk_start, ss_valid, ss_ready;

  always #5 clk = ~clk;

  ss_restore_reader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .ddr_addr       (ddr_addr),
    .ddr_req        (ddr_req),
    .ddr_rdata      (ddr_rdata),
    .ddr_rvalid     (ddr_rvalid),
    .ss_idx         (ss_idx),
    .ss_chunk_start (ss_chunk_start),
    .ss_data        (ss_data),
    .ss_valid       (ss_valid),
    .ss_ready       (ss_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] mem [64];
  logic [63:0] got_data[$], exp_data[$];
  logic [7:0]  got_idx[$], exp_idx[$];
  int          done_cnt, overlap_cnt, stab_cnt;
  logic        exp_done, exp_err;
  logic [31:0] exp_addr;
  int          ready_mode = 0;  // 0 tied high, 1 random, 2 manual
  logic        ready_manual = 1'b0;

  function automatic logic [63:0] hdr(input logic [15:0] m, input logic [7:0] i,
                                      input logic [31:0] l);
    return {m, i, 8'h00, l};
  endfunction

  function automatic logic [63:0] rd(input int p);
    return (p >= 0 && p < 64) ? mem[p] : 64'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 64'd0;
  endtask

  // Walk the stream from the rules: header, payload, (checksum), until terminator or error
  task automatic model_run();
    int p = 0;
    logic [63:0] h, x;
    int unsigned len;
    exp_data.delete(); exp_idx.delete();
    exp_done = 0; exp_err = 0;
    while (1) begin
      h = rd(p); p++;
      len = h[31:0];
      if (h[63:48] != 16'h5353 || (h[47:40] != 8'hFF && h[47:40] >= NIDX) || len > MAXW) begin
        exp_err = 1; break;
      end
      if (h[47:40] == 8'hFF) begin exp_done = 1; break; end
      exp_idx.push_back(h[47:40]);
      x = 64'd0;
      for (int k = 0; k < int'(len); k++) begin
        exp_data.push_back(rd(p)); x ^= rd(p); p++;
      end
`ifdef SS_RESTORE_CHECKSUM_EN
      if (len > 0) begin
        h = rd(p); p++;
        if (h != (x ^ SEED)) begin exp_err = 1; break; end
      end
`endif
    end
    exp_addr = BASE + 32'(p * 8);
  endtask

  // DDR responder: random latency, data from mem at the requested address
  initial begin
    int dly = 0;
    ddr_rvalid = 1'b0;
    ddr_rdata  = 64'd0;
    forever begin
      @(posedge clk); #1;
      ddr_rvalid = 1'b0;
      if (!reset_n) dly = 0;
      else if (ddr_req) begin
        if (dly == 0) begin
          ddr_rvalid = 1'b1;
          ddr_rdata  = rd(int'((ddr_addr - BASE) >> 3));
          dly = $urandom_range(0, 2);
        end else dly--;
      end
    end
  end

  initial begin
    ss_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) ss_ready = 1'b1;
      else if (ready_mode == 1) ss_ready = 1'($urandom_range(0, 1));
      else ss_ready = ready_manual;
    end
  end

  // Monitor: collects transfers, chunk starts and done pulses; flags protocol breaks
  initial begin
    logic prev_stall = 1'b0;
    logic [63:0] prev_data = 64'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) prev_stall = 1'b0;
      else begin
        if (prev_stall && (!ss_valid || ss_data != prev_data)) stab_cnt++;
        if (ss_valid && ss_ready) got_data.push_back(ss_data);
        if (ss_chunk_start) got_idx.push_back(ss_idx);
        if (done) done_cnt++;
        if (ddr_req && ss_valid) overlap_cnt++;
        prev_stall = ss_valid && !ss_ready;
        prev_data  = ss_data;
      end
    end
  end

  task automatic clear_obs();
    got_data.delete(); got_idx.delete();
    done_cnt = 0; overlap_cnt = 0; stab_cnt = 0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int cyc = 0;
    while (busy && cyc < 3000) begin @(negedge clk); cyc++; end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: busy still %b after %0d cycles", tag, busy, cyc);
      reset_n = 1'b0; #3 reset_n = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_model(input string tag);
    check({tag, " done"}, 64'(done_cnt), 64'(exp_done));
    check({tag, " error"}, 64'(error), 64'(exp_err));
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " addr"}, 64'(ddr_addr), 64'(exp_addr));
    check({tag, " ndata"}, 64'(got_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size(); i++)
      check({tag, " data"}, (i < got_data.size()) ? got_data[i] : 64'bx, exp_data[i]);
    check({tag, " nchunk"}, 64'(got_idx.size()), 64'(exp_idx.size()));
    for (int i = 0; i < exp_idx.size(); i++)
      check({tag, " idx"}, (i < got_idx.size()) ? 64'(got_idx[i]) : 64'bx, 64'(exp_idx[i]));
    check({tag, " req_while_valid"}, 64'(overlap_cnt), 64'd0);
    check({tag, " stall_stable"}, 64'(stab_cnt), 64'd0);
  endtask

  task automatic run_stream(input string tag);
    clear_obs();
    model_run();
    do_start();
    check({tag, " err_clr"}, 64'(error), 64'd0);
    wait_end(tag);
    compare_model(tag);
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = hdr(16'h5353, 8'd3, 32'd2);
    mem[1] = 64'h1111;
    mem[2] = 64'h2222;
`ifdef SS_RESTORE_CHECKSUM_EN
    mem[3] = 64'h1111 ^ 64'h2222 ^ SEED;
    mem[4] = TERM;
`else
    mem[3] = TERM;
`endif
  endtask

  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (!ss_valid && cyc < 200) begin @(negedge clk); cyc++; end
    check({tag, " valid_seen"}, 64'(ss_valid), 64'd1);
  endtask

  typedef struct {
    logic [63:0] hdr_w;
    logic        exp_err;
    logic        exp_done;
    int          exp_chunks;
  } vec_t;

  initial begin
    vec_t vt[7];
    logic [31:0] basic_end;
    vt[0] = '{hdr(16'h5354, 8'd3, 32'd0), 1'b1, 1'b0, 0};
    vt[1] = '{hdr(16'h5353, 8'd18, 32'd0), 1'b1, 1'b0, 0};
    vt[2] = '{hdr(16'h5353, 8'd17, 32'd0), 1'b0, 1'b1, 1};
    vt[3] = '{TERM, 1'b0, 1'b1, 0};
    vt[4] = '{hdr(16'h5353, 8'd2, MAXW + 32'd1), 1'b1, 1'b0, 0};
    vt[5] = '{hdr(16'h5353, 8'd0, 32'd0), 1'b0, 1'b1, 1};
    vt[6] = '{hdr(16'h5353, 8'hFF, MAXW + 32'd1), 1'b1, 1'b0, 0};
`ifdef SS_RESTORE_CHECKSUM_EN
    basic_end = BASE + 32'd40;
`else
    basic_end = BASE + 32'd32;
`endif

    reset_n = 1'b0; start = 1'b0;
    clear_obs();
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst error", 64'(error), 64'd0);
    check("rst req", 64'(ddr_req), 64'd0);
    check("rst valid", 64'(ss_valid), 64'd0);
    check("rst addr", 64'(ddr_addr), 64'(BASE));
    @(negedge clk) reset_n = 1'b1;

    // Basic stream, ready tied high
    ready_mode = 0;
    load_basic();
    run_stream("basic");
    check("basic final_addr", 64'(ddr_addr), 64'(basic_end));
    check("basic idx3", (got_idx.size() > 0) ? 64'(got_idx[0]) : 64'bx, 64'd3);
    check("basic d1", (got_data.size() > 1) ? got_data[1] : 64'bx, 64'h2222);

    // Five-cycle stall on D0
    ready_mode = 2; ready_manual = 1'b0;
    load_basic();
    clear_obs(); model_run();
    do_start();
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      check("stall valid", 64'(ss_valid), 64'd1);
      check("stall data", ss_data, 64'h1111);
      check("stall no_req", 64'(ddr_req), 64'd0);
      @(negedge clk);
    end
    ready_manual = 1'b1;
    wait_end("stall");
    compare_model("stall");
    ready_mode = 0;

    // Header table
    foreach (vt[v]) begin
      clear_mem();
      mem[0] = vt[v].hdr_w;
      mem[1] = TERM;
      clear_obs();
      do_start();
      check("tbl err_clr", 64'(error), 64'd0);
      wait_end("tbl");
      check($sformatf("tbl%0d error", v), 64'(error), 64'(vt[v].exp_err));
      check($sformatf("tbl%0d done", v), 64'(done_cnt), 64'(vt[v].exp_done));
      check($sformatf("tbl%0d chunks", v), 64'(got_idx.size()), 64'(vt[v].exp_chunks));
      check($sformatf("tbl%0d nodata", v), 64'(got_data.size()), 64'd0);
      check($sformatf("tbl%0d busy", v), 64'(busy), 64'd0);
    end

    // Reset while a word is waiting in DAT_OUT
    ready_mode = 2; ready_manual = 1'b0;
    load_basic();
    clear_obs();
    do_start();
    wait_valid("mrst");
    reset_n = 1'b0;
    #1;
    check("mrst busy", 64'(busy), 64'd0);
    check("mrst valid", 64'(ss_valid), 64'd0);
    check("mrst data", ss_data, 64'd0);
    check("mrst idx", 64'(ss_idx), 64'd0);
    check("mrst req", 64'(ddr_req), 64'd0);
    check("mrst addr", 64'(ddr_addr), 64'(BASE));
    @(negedge clk) reset_n = 1'b1;
    ready_mode = 0;
    run_stream("after_rst");

`ifdef SS_RESTORE_CHECKSUM_EN
    clear_mem();
    mem[0] = hdr(16'h5353, 8'd3, 32'd2);
    mem[1] = 64'h1111;
    mem[2] = 64'h0000;
    mem[3] = 64'hA5A5_A5A5_A5A5_B4B4;
    mem[4] = TERM;
    run_stream("csum_ok");
    check("csum_ok done", 64'(done_cnt), 64'd1);
    mem[3] = 64'hA5A5_A5A5_A5A5_B4B5;
    run_stream("csum_bad");
    check("csum_bad error", 64'(error), 64'd1);
`endif

    // Randomized streams
    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      int p = 0;
      int nch = $urandom_range(1, 3);
      clear_mem();
      for (int c = 0; c < nch; c++) begin
        int len = $urandom_range(0, 4);
        logic [63:0] x = 64'd0;
        mem[p++] = hdr(16'h5353, 8'($urandom_range(0, NIDX - 1)), 32'(len));
        for (int k = 0; k < len; k++) begin
          mem[p] = {$urandom, $urandom};
          x ^= mem[p];
          p++;
        end
`ifdef SS_RESTORE_CHECKSUM_EN
        if (len > 0) mem[p++] = x ^ SEED;
`endif
      end
      mem[p++] = TERM;
      if ($urandom_range(0, 5) == 0)
        mem[$urandom_range(0, p - 1)][$urandom_range(32, 63)] ^= 1'b1;
      run_stream($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ss_restore_reader.md
Name: ss_restore_reader

Overview:
Save-state restore engine. It is the reader counterpart of the save-state writer that dumps chunks to DDR at SS_DDR_BASE (0x3E00_0000). On a restore request it walks the chunk stream in DDR, validates each chunk header, and replays that chunk's 64-bit payload words to the unit selected by the chunk's SSIDX. Each word is delivered over a valid/ready handshake. It sits between the DDR read arbiter port and the per-unit save-state buses (SSIDX_GLOBAL..SSIDX_480SCP).

Parameters:
- BASE_ADDR, 32'h3E00_0000: byte address of the first chunk header.
- NUM_IDX, 18: number of legal SSIDX values; valid range is 0..NUM_IDX-1.
- MAX_WORDS, 32'h0010_0000: maximum legal payload length per chunk, in 64-bit words.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin restore
- busy  out  1  high from start acceptance until DONE/ERROR
- done  out  1  one-cycle pulse when the terminator is reached
- error  out  1  sticky until the next accepted start
- ddr_addr  out  32  byte address; 8-byte aligned
- ddr_req  out  1  held high until ddr_rvalid
- ddr_rdata  in  64  read data
- ddr_rvalid  in  1  one-cycle pulse completing the request
- ss_idx  out  8  SSIDX of the current chunk
- ss_chunk_start  out  1  one-cycle pulse before the first word of a chunk
- ss_data  out  64  payload word
- ss_valid  out  1  payload word valid
- ss_ready  in  1  destination accepts the word

Behaviour:
Interface:
- One clock. Reset is asynchronous and active-low (clk, reset_n).
- Reset values: all outputs 0; state = IDLE; ddr_addr = BASE_ADDR.

Header word format:
- [63:48] magic 16'h5353.
- [47:40] ssidx.
- [39:32] reserved (ignored).
- [31:0] payload length in 64-bit words.
- Terminator: magic with ssidx = 8'hFF.

States:
- IDLE: on start, set ddr_addr = BASE_ADDR, clear error, set busy, go to HDR_RD. start is ignored while busy.
- HDR_RD: assert ddr_req. On ddr_rvalid, decode the header and advance ddr_addr by 8.
  - Bad magic, or ssidx not 8'hFF and ssidx ≥ NUM_IDX, or length > MAX_WORDS → ERROR.
  - Terminator → DONE.
  - length = 0 → pulse ss_chunk_start and go to HDR_RD.
  - Otherwise latch ss_idx and the word count, pulse ss_chunk_start next cycle, go to DAT_RD.
- DAT_RD: assert ddr_req. On ddr_rvalid, register ss_data, set ss_valid, advance ddr_addr by 8, go to DAT_OUT.
- DAT_OUT: hold ss_data and ss_valid stable until ss_valid && ss_ready; the transfer occurs in that cycle. Then decrement the count.
  - Count becomes 0 → HDR_RD (or CSUM_RD, see Optional Feature).
  - Otherwise → DAT_RD.
- DONE: pulse done, drop busy, go to IDLE.
- ERROR: set error, drop busy and ss_valid, go to IDLE.

Timing and arithmetic:
- Minimum latency per word: 1 cycle after ddr_rvalid to ss_valid. There is no prefetch; a single-word buffer is used.
- ddr_addr increments modulo 2^32. Wrap-around is not an error.
- ddr_req drops in the cycle after ddr_rvalid. It is never asserted while ss_valid is high.
- ddr_rvalid with ddr_req low is ignored.
- ss_ready while ss_valid is low has no effect.
- reset_n asserted mid-chunk returns immediately to the reset state; partial chunk delivery is the destination's concern.

Optional Feature:
- Macro SS_RESTORE_CHECKSUM_EN.
- Enabled: each non-empty chunk's payload is followed by one checksum word. It must equal the XOR of all payload words XORed with 64'hA5A5_A5A5_A5A5_A5A5.
  - The running XOR accumulates on each handshake.
  - Added state CSUM_RD fetches the checksum word; mismatch → ERROR, match → HDR_RD.
  - Zero-length chunks have no checksum word.
- Disabled: no checksum word is read or expected; CSUM_RD and the accumulator are absent.

Decomposition:
- Add to package system_consts:
  - SS_CHUNK_MAGIC = 16'h5353
  - SS_IDX_TERMINATOR = 8'hFF
  - SS_CSUM_SEED = 64'hA5A5_A5A5_A5A5_A5A5
  - packed struct ss_chunk_hdr_t {magic[15:0], idx[7:0], rsvd[7:0], length[31:0]}
  - state enum ss_restore_state_t
- One sub-module, ss_ddr_word_fetch: owns ddr_req/ddr_addr/ddr_rdata capture and the address increment. The parent FSM issues "fetch" and receives "word_valid".

Test Plan:
- Stream [hdr idx=3 len=2, D0=64'h1111, D1=64'h2222, term], ss_ready tied 1 → ss_chunk_start once with ss_idx=3; ss_data 1111 then 2222; one done pulse; error=0; final ddr_addr=BASE_ADDR+32.
- Same stream, ss_ready low for 5 cycles on D0 → ss_data/ss_valid stable for 5 cycles; no ddr_req during the stall; same final output.
- Header magic 16'h5354 → error=1, busy=0, no ss_valid, no done; next start clears error.
- Header idx=18 (NUM_IDX=18) → ERROR. Header idx=17 len=0 followed by term → chunk_start pulse, no data, done.
- reset_n low during DAT_OUT → all outputs 0 next cycle. Start afterwards re-reads from BASE_ADDR.
- With SS_RESTORE_CHECKSUM_EN: correct checksum word 64'hA5A5_A5A5_A5A5_B4B4 for D0 = 64'h1111 and D1 = 64'h0000 → done. Corrupted checksum → error=1.
